// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: FSM state encodings and default sizing shared by the hazard scoreboard.
package hazard_scoreboard_pkg;
  typedef enum logic {SB_IDLE, SB_FLUSH} sb_state_e;
  localparam int SB_MAX_INFLIGHT = 3;
  localparam int SB_CNT_W = 3;
  localparam int SB_FLUSH_CYCLES = 2;
  localparam int SB_FLUSH_W = 4;
endpackage

// File: rtl/hazard_scoreboard_sb_pending_counter.sv
// sb_pending_counter: saturating up/down counter of outstanding writes to one register.
module sb_pending_counter #(
  parameter int MAX = 3,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         full,
  output logic         empty,
  output logic         overflow,
  output logic         underflow
);
  assign full = count == W'(MAX);
  assign empty = count == '0;
  assign overflow = inc && !dec && full;
  assign underflow = dec && !inc && empty;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clr) count <= '0;
    else if (inc && !dec && !full) count <= count + W'(1);
    else if (dec && !inc && !empty) count <= count - W'(1);
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight A/X writes and sequences the mispredict flush.
// Optional same-cycle retire bypass: define HAZARD_SCOREBOARD_BYPASS_EN.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT,
  parameter int CNT_W = SB_CNT_W,
  parameter int FLUSH_CYCLES = SB_FLUSH_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  input  logic             issue_wr_A,
  input  logic             issue_wr_X,
  input  logic             retire_A,
  input  logic             retire_X,
  input  logic             branch_mispredict,
  output logic             issue_rdy,
  output logic             stage2_writes_A,
  output logic             stage2_writes_X,
  output logic             flush_hold,
  output logic [CNT_W-1:0] pending_A,
  output logic [CNT_W-1:0] pending_X,
  output logic             err
);
  sb_state_e state;
  logic [SB_FLUSH_W-1:0] flush_cnt;
  logic en, free_a, free_x;
  logic full_a, full_x, empty_a, empty_x, ovf_a, ovf_x, unf_a, unf_x;
`ifdef HAZARD_SCOREBOARD_BYPASS_EN
  assign free_a = !full_a || retire_A;
  assign free_x = !full_x || retire_X;
  assign stage2_writes_A = !empty_a && !(retire_A && pending_A == CNT_W'(1));
  assign stage2_writes_X = !empty_x && !(retire_X && pending_X == CNT_W'(1));
`else
  assign free_a = !full_a;
  assign free_x = !full_x;
  assign stage2_writes_A = !empty_a;
  assign stage2_writes_X = !empty_x;
`endif
  assign issue_rdy = free_a && free_x && state == SB_IDLE;
  // the mispredict cycle itself carries killed instructions, so counting is gated off
  assign en = state == SB_IDLE && !branch_mispredict;
  sb_pending_counter #(.MAX(MAX_INFLIGHT), .W(CNT_W)) u_cnt_a (
    .clk(clk), .rst(rst), .inc(en && issue && issue_wr_A && issue_rdy), .dec(en && retire_A),
    .clr(branch_mispredict), .count(pending_A), .full(full_a), .empty(empty_a),
    .overflow(ovf_a), .underflow(unf_a)
  );
  sb_pending_counter #(.MAX(MAX_INFLIGHT), .W(CNT_W)) u_cnt_x (
    .clk(clk), .rst(rst), .inc(en && issue && issue_wr_X && issue_rdy), .dec(en && retire_X),
    .clr(branch_mispredict), .count(pending_X), .full(full_x), .empty(empty_x),
    .overflow(ovf_x), .underflow(unf_x)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= SB_IDLE;
      flush_cnt <= '0;
      flush_hold <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= err || (en && (ovf_a || ovf_x || unf_a || unf_x || (issue && !issue_rdy)));
      if (branch_mispredict) begin
        state <= SB_FLUSH;
        flush_cnt <= SB_FLUSH_W'(FLUSH_CYCLES);
        flush_hold <= 1'b1;
      end else if (state == SB_FLUSH) begin
        flush_cnt <= flush_cnt - SB_FLUSH_W'(1);
        if (flush_cnt == SB_FLUSH_W'(1)) begin
          state <= SB_IDLE;
          flush_hold <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed plus random stimulus against an integer reference model.
module tb_hazard_scoreboard;
  localparam int MAX = 3;
  localparam int CW = 3;
  localparam int FC = 2;
`ifdef HAZARD_SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 0, rst = 0;
  logic issue = 0, wa = 0, wx = 0, ra = 0, rx = 0, bm = 0;
  logic rdy, s2a, s2x, fh, err;
  logic [CW-1:0] pa, px;
  int checks = 0, errors = 0;
  int m_pa = 0, m_px = 0, m_fl = 0;
  bit m_err = 0;

  hazard_scoreboard #(.MAX_INFLIGHT(MAX), .CNT_W(CW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .issue(issue), .issue_wr_A(wa), .issue_wr_X(wx),
    .retire_A(ra), .retire_X(rx), .branch_mispredict(bm), .issue_rdy(rdy),
    .stage2_writes_A(s2a), .stage2_writes_X(s2x), .flush_hold(fh),
    .pending_A(pa), .pending_X(px), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_rdy();
    bit fa, fx;
    fa = m_pa == MAX && !(BYP && ra);
    fx = m_px == MAX && !(BYP && rx);
    return m_fl == 0 && !fa && !fx;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".pending_A"}, 32'(pa), m_pa);
    chk({tag, ".pending_X"}, 32'(px), m_px);
    chk({tag, ".flush_hold"}, 32'(fh), 32'(m_fl != 0));
    chk({tag, ".err"}, 32'(err), 32'(m_err));
    chk({tag, ".issue_rdy"}, 32'(rdy), 32'(m_rdy()));
    chk({tag, ".writes_A"}, 32'(s2a), 32'(m_pa != 0 && !(BYP && ra && m_pa == 1)));
    chk({tag, ".writes_X"}, 32'(s2x), 32'(m_px != 0 && !(BYP && rx && m_px == 1)));
  endtask

  task automatic model_step();
    bit r, ia, ix;
    r = m_rdy();
    if (bm) begin
      m_pa = 0;
      m_px = 0;
      m_fl = FC;
    end else if (m_fl > 0) m_fl--;
    else begin
      if (issue && !r) m_err = 1;
      ia = issue && wa && r;
      ix = issue && wx && r;
      if (ia && !ra) m_pa++;
      else if (ra && !ia) begin
        if (m_pa == 0) m_err = 1;
        else m_pa--;
      end
      if (ix && !rx) m_px++;
      else if (rx && !ix) begin
        if (m_px == 0) m_err = 1;
        else m_px--;
      end
    end
  endtask

  task automatic cyc(input string tag, input logic i, input logic a, input logic x,
                     input logic rta, input logic rtx, input logic b);
    issue = i; wa = a; wx = x; ra = rta; rx = rtx; bm = b;
    #1;
    check_all(tag);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    {issue, wa, wx, ra, rx, bm} = '0;
    rst = 1;
    #1;
    m_pa = 0; m_px = 0; m_fl = 0; m_err = 0;
    check_all(tag);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    do_reset("reset");
    for (int k = 0; k < 5; k++) cyc("idle", 0, 0, 0, 0, 0, 0);
    cyc("issA", 1, 1, 0, 0, 0, 0);
    cyc("holdA1", 0, 0, 0, 0, 0, 0);
    cyc("holdA2", 0, 0, 0, 0, 0, 0);
    cyc("retA", 0, 0, 0, 1, 0, 0);
    cyc("afterA", 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc("fillA", 1, 1, 0, 0, 0, 0);
    cyc("fullA", 1, 1, 0, 0, 0, 0);
    cyc("fullA_err", 0, 0, 0, 0, 0, 0);
    do_reset("reset2");
    cyc("issX1", 1, 0, 1, 0, 0, 0);
    cyc("issX2", 1, 0, 1, 0, 0, 0);
    cyc("issret", 1, 0, 1, 0, 1, 0);
    cyc("x_stays", 0, 0, 0, 0, 0, 0);
    do_reset("reset3");
    cyc("pA1", 1, 1, 1, 0, 0, 0);
    cyc("pA2", 1, 1, 0, 0, 0, 0);
    cyc("mispred", 0, 0, 0, 0, 0, 1);
    cyc("flush1", 1, 1, 1, 1, 1, 0);
    cyc("flush2", 1, 1, 1, 0, 0, 0);
    cyc("postflush", 0, 0, 0, 0, 0, 0);
    cyc("undX", 0, 0, 0, 0, 1, 0);
    cyc("undX_err", 0, 0, 0, 0, 0, 0);
    cyc("mispred2", 0, 0, 0, 0, 0, 1);
    rst = 1;
    #1;
    m_pa = 0; m_px = 0; m_fl = 0; m_err = 0;
    check_all("rst_midflush");
    @(posedge clk);
    #1;
    rst = 0;
    cyc("after_rst", 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      if (n % 60 == 59) do_reset("rnd_reset");
      else cyc("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 24) == 0));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
